// File: rtl/primus_core_pkg.sv
// Shared types and encodings for the primus core memory/writeback path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package primus_core_pkg;

  typedef enum logic [1:0] {
    MEM_NONE,
    MEM_LOAD,
    MEM_STORE
  } mem_op_e;

  // RV32I funct3 encodings for loads and stores
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT
  } lsu_state_e;

  typedef enum logic [1:0] {
    SZ_BYTE,
    SZ_HALF,
    SZ_WORD
  } acc_size_e;

  // Access size from funct3; any encoding not defined for the op is a word.
  function automatic acc_size_e decode_size(input logic is_store, input logic [2:0] funct3);
    acc_size_e sz;
    sz = SZ_WORD;
    if (funct3 == F3_LB) begin
      sz = SZ_BYTE;             // SB shares this encoding
    end else if (funct3 == F3_LH) begin
      sz = SZ_HALF;             // SH shares this encoding
    end else if (!is_store && funct3 == F3_LBU) begin
      sz = SZ_BYTE;
    end else if (!is_store && funct3 == F3_LHU) begin
      sz = SZ_HALF;
    end
    return sz;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for stores, load extraction/sign-extension, misalignment detect.
// Latency: purely combinational.
// Backpressure: none; stateless.
module lsu_align
  import primus_core_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] rs2,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic        misaligned
);

  acc_size_e   size;
  logic        is_signed;
  logic [31:0] shifted;

  // Decode size, steer store lanes and pull the addressed bytes down to bit 0
  always_comb begin
    size       = decode_size(is_store, funct3);
    is_signed  = !is_store && (funct3 == F3_LB || funct3 == F3_LH);
    shifted    = rdata >> {addr_lo, 3'b000};
    be         = 4'hF;
    wdata      = rs2;
    load_data  = shifted;
    misaligned = 1'b0;
    case (size)
      SZ_BYTE: begin
        be        = 4'b0001 << addr_lo;
        wdata     = {4{rs2[7:0]}};
        load_data = is_signed ? {{24{shifted[7]}}, shifted[7:0]} : {24'b0, shifted[7:0]};
      end
      SZ_HALF: begin
        be         = 4'b0011 << addr_lo;
        wdata      = {2{rs2[15:0]}};
        load_data  = is_signed ? {{16{shifted[15]}}, shifted[15:0]} : {16'b0, shifted[15:0]};
        misaligned = addr_lo[0];
      end
      default: begin
        misaligned = (addr_lo != 2'b00);
      end
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// Memory access + register-file writeback stage: issues dmem req/gnt/rvalid, writes rd.
// Latency: ALU result writes back 1 cycle after accept; loads 1 cycle after rvalid.
// Backpressure: ex_ready_o low while a memory op is in flight and during a load's writeback cycle.
module mem_wb_stage
  import primus_core_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  ex_valid_i,
  output logic                  ex_ready_o,
  input  logic [XLEN-1:0]       ex_alu_res_i,
  input  logic [XLEN-1:0]       ex_rs2_i,
  input  logic [REG_ADDR_W-1:0] ex_rd_i,
  input  logic                  ex_wb_en_i,
  input  mem_op_e               ex_mem_op_i,
  input  logic [2:0]            ex_funct3_i,
  output logic                  dmem_req_o,
  input  logic                  dmem_gnt_i,
  output logic                  dmem_we_o,
  output logic [XLEN-1:0]       dmem_addr_o,
  output logic [3:0]            dmem_be_o,
  output logic [XLEN-1:0]       dmem_wdata_o,
  input  logic                  dmem_rvalid_i,
  input  logic [XLEN-1:0]       dmem_rdata_i,
  output logic                  wb_w_en_o,
  output logic [REG_ADDR_W-1:0] wb_w_addr_o,
  output logic [XLEN-1:0]       wb_w_data_o,
  output logic                  misalign_o
);

  lsu_state_e            state;
  logic [1:0]            pend_lo;
  logic [2:0]            pend_f3;
  logic [REG_ADDR_W-1:0] pend_rd;
  logic                  pend_wb;

  logic                  accept;
  logic                  wb_ok;
  logic                  is_mem;
  logic                  sel_store;
  logic [1:0]            sel_lo;
  logic [2:0]            sel_f3;
  logic [3:0]            al_be;
  logic [XLEN-1:0]       al_wdata;
  logic [XLEN-1:0]       al_load_data;
  logic                  al_misaligned;

  // In IDLE the aligner looks at the incoming EX op; once a load is in
  // flight it looks at the latched offset/funct3 to extract rdata.
  always_comb begin
    accept    = ex_valid_i && ex_ready_o;
    wb_ok     = ex_wb_en_i && (ex_rd_i != '0);
    is_mem    = (ex_mem_op_i == MEM_LOAD) || (ex_mem_op_i == MEM_STORE);
    sel_store = (state == IDLE) ? (ex_mem_op_i == MEM_STORE) : dmem_we_o;
    sel_lo    = (state == IDLE) ? ex_alu_res_i[1:0] : pend_lo;
    sel_f3    = (state == IDLE) ? ex_funct3_i : pend_f3;
  end

  lsu_align u_align (
    .addr_lo    (sel_lo),
    .is_store   (sel_store),
    .funct3     (sel_f3),
    .rs2        (ex_rs2_i),
    .rdata      (dmem_rdata_i),
    .be         (al_be),
    .wdata      (al_wdata),
    .load_data  (al_load_data),
    .misaligned (al_misaligned)
  );

  // LSU FSM with registered request, handshake and writeback outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= IDLE;
      ex_ready_o   <= 1'b1;
      dmem_req_o   <= 1'b0;
      dmem_we_o    <= 1'b0;
      dmem_addr_o  <= '0;
      dmem_be_o    <= '0;
      dmem_wdata_o <= '0;
      wb_w_en_o    <= 1'b0;
      wb_w_addr_o  <= '0;
      wb_w_data_o  <= '0;
      misalign_o   <= 1'b0;
      pend_lo      <= '0;
      pend_f3      <= '0;
      pend_rd      <= '0;
      pend_wb      <= 1'b0;
    end else begin
      wb_w_en_o  <= 1'b0;
      misalign_o <= 1'b0;
      case (state)
        IDLE: begin
          // also re-opens the input after a load's writeback cycle
          ex_ready_o <= 1'b1;
          if (accept) begin
            if (is_mem) begin
              if (al_misaligned) begin
                misalign_o <= 1'b1;
              end else begin
                state        <= REQ;
                ex_ready_o   <= 1'b0;
                dmem_req_o   <= 1'b1;
                dmem_we_o    <= (ex_mem_op_i == MEM_STORE);
                dmem_addr_o  <= {ex_alu_res_i[XLEN-1:2], 2'b00};
                dmem_be_o    <= al_be;
                dmem_wdata_o <= al_wdata;
                pend_lo      <= ex_alu_res_i[1:0];
                pend_f3      <= ex_funct3_i;
                pend_rd      <= ex_rd_i;
                pend_wb      <= wb_ok;
              end
            end else begin
              wb_w_en_o   <= wb_ok;
              wb_w_addr_o <= ex_rd_i;
              wb_w_data_o <= ex_alu_res_i;
            end
          end
        end
        REQ: begin
          if (dmem_gnt_i) begin
            dmem_req_o <= 1'b0;
            if (dmem_we_o) begin
              state      <= IDLE;
              ex_ready_o <= 1'b1;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          // ex_ready_o stays low through the writeback cycle that follows
          if (dmem_rvalid_i) begin
            state       <= IDLE;
            wb_w_en_o   <= pend_wb;
            wb_w_addr_o <= pend_rd;
            wb_w_data_o <= al_load_data;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
